// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the shared-ALU / shared-memory MIPS
// datapath. Sequences FETCH/DECODE/EXEC/MEM/WB, drives the datapath write
// enables and mux selects, stalls in MEM on memReady and counts retired
// instructions.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN -- undecoded instructions
// trap into a sticky HALT state instead of executing as nop.
module mc_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                memReady,
  output logic                irWE,
  output logic                pcWE,
  output logic                regWE,
  output logic                dmWE,
  output logic                dmRE,
  output logic [2:0]          aluOp,
  output logic                aluSrc,
  output logic                usExt,
  output logic [1:0]          regDesCtrl,
  output logic [1:0]          regDataCtrl,
  output logic [2:0]          nextPCop,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire_d;

  // Raw enables before the reset gate
  logic irWERaw, pcWERaw, regWERaw, dmWERaw, dmRERaw;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       isRtype;
  logic       isAddu, isSubu, isJr;
  logic       isOri, isLui, isLw, isSw, isBeq, isJ, isJal, isNop;
  logic       isDecoded;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Instruction decode, shared by next-state and output logic
  always_comb begin
    isRtype   = (opcode == 6'h00);
    isAddu    = isRtype && (funct == 6'h21);
    isSubu    = isRtype && (funct == 6'h23);
    isJr      = isRtype && (funct == 6'h08);
    isOri     = (opcode == 6'h0d);
    isLui     = (opcode == 6'h0f);
    isLw      = (opcode == 6'h23);
    isSw      = (opcode == 6'h2b);
    isBeq     = (opcode == 6'h04);
    isJ       = (opcode == 6'h02);
    isJal     = (opcode == 6'h03);
    isNop     = (instr == 32'h0000_0000);
    isDecoded = isAddu | isSubu | isJr | isOri | isLui | isLw | isSw |
                isBeq | isJ | isJal | isNop;
  end

  // State and retire-counter registers; reset returns to FETCH at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  // Next state; retire_d marks the last cycle of an instruction
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (isAddu || isSubu || isOri || isLui) begin
          state_d = WB;
        end else if (isLw || isSw) begin
          state_d = MEM;
        end else if (isDecoded) begin
          state_d  = FETCH;
          retire_d = 1'b1;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d  = HALT;
`else
          state_d  = FETCH;
          retire_d = 1'b1;
`endif
        end
      end
      MEM: begin
        if (memReady) begin
          if (isLw) begin
            state_d = WB;
          end else begin
            state_d  = FETCH;
            retire_d = 1'b1;
          end
        end
      end
      WB: begin
        state_d  = FETCH;
        retire_d = 1'b1;
      end
      HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        state_d = HALT;
`else
        state_d = FETCH;
`endif
      end
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls decoded from the current state and instruction
  always_comb begin
    irWERaw     = 1'b0;
    pcWERaw     = 1'b0;
    regWERaw    = 1'b0;
    dmWERaw     = 1'b0;
    dmRERaw     = 1'b0;
    aluOp       = 3'd0;
    aluSrc      = 1'b0;
    usExt       = 1'b0;
    regDesCtrl  = 2'd0;
    regDataCtrl = 2'd0;
    nextPCop    = 3'd0;
    case (state_q)
      FETCH: begin
        irWERaw  = 1'b1;
        pcWERaw  = 1'b1;
        nextPCop = 3'd0;
      end
      EXEC: begin
        if (isAddu) begin
          aluOp = 3'd0;
        end else if (isSubu) begin
          aluOp = 3'd1;
        end else if (isOri) begin
          aluOp  = 3'd2;
          aluSrc = 1'b1;
          usExt  = 1'b1;
        end else if (isLui) begin
          aluOp  = 3'd3;
          aluSrc = 1'b1;
        end else if (isLw || isSw) begin
          aluOp  = 3'd0;
          aluSrc = 1'b1;
        end else if (isBeq) begin
          aluOp    = 3'd1;
          pcWERaw  = zero;
          nextPCop = 3'd1;
        end else if (isJ) begin
          pcWERaw  = 1'b1;
          nextPCop = 3'd2;
        end else if (isJal) begin
          pcWERaw     = 1'b1;
          nextPCop    = 3'd2;
          regWERaw    = 1'b1;
          regDesCtrl  = 2'd2;
          regDataCtrl = 2'd2;
        end else if (isJr) begin
          pcWERaw  = 1'b1;
          nextPCop = 3'd3;
        end
      end
      MEM: begin
        dmRERaw = isLw;
        dmWERaw = isSw;
      end
      WB: begin
        regWERaw = 1'b1;
        if (isAddu || isSubu) begin
          regDesCtrl = 2'd1;
        end else if (isLw) begin
          regDataCtrl = 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Reset gates every write enable so nothing commits while it is held
  assign irWE  = irWERaw  & ~reset;
  assign pcWE  = pcWERaw  & ~reset;
  assign regWE = regWERaw & ~reset;
  assign dmWE  = dmWERaw  & ~reset;
  assign dmRE  = dmRERaw  & ~reset;

  assign state   = state_q;
  assign retired = retired_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench for mc_ctrl. The stimulus side
// expands each instruction into its expected per-cycle control pattern and
// queues it; a monitor compares the DUT against the queue every cycle.
module tb_mc_ctrl;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          zero;
  logic          memReady;
  logic          irWE, pcWE, regWE, dmWE, dmRE;
  logic [2:0]    aluOp;
  logic          aluSrc, usExt;
  logic [1:0]    regDesCtrl, regDataCtrl;
  logic [2:0]    nextPCop;
  logic [2:0]    state;
  logic [RW-1:0] retired;
  logic          halted;

  mc_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .memReady(memReady),
    .irWE(irWE), .pcWE(pcWE), .regWE(regWE), .dmWE(dmWE), .dmRE(dmRE),
    .aluOp(aluOp), .aluSrc(aluSrc), .usExt(usExt), .regDesCtrl(regDesCtrl),
    .regDataCtrl(regDataCtrl), .nextPCop(nextPCop), .state(state),
    .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          irWE, pcWE, regWE, dmWE, dmRE;
    logic [2:0]    aluOp;
    logic          aluSrc, usExt;
    logic [1:0]    regDesCtrl, regDataCtrl;
    logic [2:0]    nextPCop;
    logic          halted;
    logic [RW-1:0] retired;
  } exp_t;

  typedef struct {
    exp_t e;
    logic mrCtl;
    logic mrVal;
    logic zCtl;
    logic zVal;
  } step_t;

  typedef enum int {
    kAddu, kSubu, kJr, kOri, kLui, kLw, kSw, kBeq, kJ, kJal, kNop, kIll
  } kind_t;

  exp_t          expQ[$];
  step_t         plan[$];
  logic [RW-1:0] retiredModel = '0;
  int            errors = 0;
  int            checks = 0;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Sort an instruction word into the instruction it names
  function automatic kind_t classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'h0) return kNop;
    if (op == 6'h00) begin
      if (fn == 6'h21) return kAddu;
      if (fn == 6'h23) return kSubu;
      if (fn == 6'h08) return kJr;
      return kIll;
    end
    case (op)
      6'h0d: return kOri;
      6'h0f: return kLui;
      6'h23: return kLw;
      6'h2b: return kSw;
      6'h04: return kBeq;
      6'h02: return kJ;
      6'h03: return kJal;
      default: return kIll;
    endcase
  endfunction

  function automatic exp_t baseRec(input logic [2:0] st);
    exp_t r;
    r         = '0;
    r.st      = st;
    r.retired = retiredModel;
    return r;
  endfunction

  function automatic void pushStep(input exp_t e, input logic mrCtl,
                                   input logic mrVal, input logic zCtl,
                                   input logic zVal);
    step_t s;
    s.e     = e;
    s.mrCtl = mrCtl;
    s.mrVal = mrVal;
    s.zCtl  = zCtl;
    s.zVal  = zVal;
    plan.push_back(s);
  endfunction

  // Monitor: compare every cycle's controls against the scoreboard
  always @(negedge clk) begin
    if (!reset && expQ.size() > 0) begin
      exp_t want;
      exp_t got;
      want = expQ.pop_front();
      got.st          = state;
      got.irWE        = irWE;
      got.pcWE        = pcWE;
      got.regWE       = regWE;
      got.dmWE        = dmWE;
      got.dmRE        = dmRE;
      got.aluOp       = aluOp;
      got.aluSrc      = aluSrc;
      got.usExt       = usExt;
      got.regDesCtrl  = regDesCtrl;
      got.regDataCtrl = regDataCtrl;
      got.nextPCop    = nextPCop;
      got.halted      = halted;
      got.retired     = retired;
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL cycleCtrl instr=%h state: got %0d expected %0d; ctrl vector: got %h expected %h",
                 instr, got.st, want.st, got, want);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Assert reset away from a clock edge, check the reset view, release
  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("rstState",   32'(state), 32'd0);
    checkOutput("rstRetired", 32'(retired), 32'd0);
    checkOutput("rstEnables", {27'd0, irWE, pcWE, regWE, dmWE, dmRE}, 32'd0);
    checkOutput("rstHalted",  32'(halted), 32'd0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    retiredModel = '0;
  endtask

  // Expand one instruction into its cycle pattern, then drive it
  task automatic applyStimulus(input logic [31:0] ins, input logic zeroVal,
                               input int stall, input int maxSteps);
    kind_t k;
    exp_t  r;
    int    n;
    bit    retires;
    k = classify(ins);
    plan.delete();
    r = baseRec(3'd0); r.irWE = 1'b1; r.pcWE = 1'b1;
    pushStep(r, 1'b0, 1'b0, 1'b0, 1'b0);
    r = baseRec(3'd1);
    pushStep(r, 1'b0, 1'b0, 1'b0, 1'b0);
    r = baseRec(3'd2);
    case (k)
      kSubu: r.aluOp = 3'd1;
      kOri:  begin r.aluOp = 3'd2; r.aluSrc = 1'b1; r.usExt = 1'b1; end
      kLui:  begin r.aluOp = 3'd3; r.aluSrc = 1'b1; end
      kLw, kSw: r.aluSrc = 1'b1;
      kBeq:  begin r.aluOp = 3'd1; r.pcWE = zeroVal; r.nextPCop = 3'd1; end
      kJ:    begin r.pcWE = 1'b1; r.nextPCop = 3'd2; end
      kJal:  begin
        r.pcWE = 1'b1; r.nextPCop = 3'd2; r.regWE = 1'b1;
        r.regDesCtrl = 2'd2; r.regDataCtrl = 2'd2;
      end
      kJr:   begin r.pcWE = 1'b1; r.nextPCop = 3'd3; end
      default: ;
    endcase
    pushStep(r, 1'b0, 1'b0, 1'b1, zeroVal);
    retires = 1'b1;
    if (k == kLw || k == kSw) begin
      for (int i = 0; i <= stall; i++) begin
        r = baseRec(3'd3);
        r.dmRE = (k == kLw);
        r.dmWE = (k == kSw);
        pushStep(r, 1'b1, (i == stall), 1'b0, 1'b0);
      end
    end
    if (k == kAddu || k == kSubu || k == kOri || k == kLui || k == kLw) begin
      r = baseRec(3'd4);
      r.regWE = 1'b1;
      if (k == kAddu || k == kSubu) r.regDesCtrl = 2'd1;
      if (k == kLw) r.regDataCtrl = 2'd1;
      pushStep(r, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (TRAP && k == kIll) begin
      retires = 1'b0;
      for (int i = 0; i < 3; i++) begin
        r = baseRec(3'd5);
        r.halted = 1'b1;
        pushStep(r, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    n = (maxSteps < 0) ? plan.size() : maxSteps;
    for (int i = 0; i < n; i++) begin
      instr    = ins;
      zero     = plan[i].zCtl  ? plan[i].zVal  : 1'($urandom);
      memReady = plan[i].mrCtl ? plan[i].mrVal : 1'($urandom);
      expQ.push_back(plan[i].e);
      @(posedge clk);
      #1;
    end
    if (n == plan.size() && retires) retiredModel = retiredModel + 1'b1;
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] idx;
    int          pick;
    rs   = 5'($urandom);
    rt   = 5'($urandom);
    rd   = 5'($urandom);
    imm  = 16'($urandom);
    idx  = 26'($urandom);
    pick = TRAP ? $urandom_range(0, 10) : $urandom_range(0, 11);
    case (pick)
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h00, rs, 15'd0, 6'h08};
      3:  return {6'h0d, rs, rt, imm};
      4:  return {6'h0f, 5'd0, rt, imm};
      5:  return {6'h23, rs, rt, imm};
      6:  return {6'h2b, rs, rt, imm};
      7:  return {6'h04, rs, rt, imm};
      8:  return {6'h02, idx};
      9:  return {6'h03, idx};
      10: return 32'h0;
      default: return {6'h3f, idx};
    endcase
  endfunction

  initial begin
    reset    = 1'b0;
    instr    = 32'h0;
    zero     = 1'b0;
    memReady = 1'b0;
    #2;
    doReset();

    applyStimulus(32'h00221821, 1'b0, 0, -1);
    applyStimulus(32'h8C040008, 1'b0, 3, -1);
    applyStimulus(32'h10220004, 1'b1, 0, -1);
    applyStimulus(32'h10220004, 1'b0, 0, -1);
    applyStimulus(32'h0C000100, 1'b0, 0, -1);
    applyStimulus(32'h08000040, 1'b0, 0, -1);
    applyStimulus(32'h03E00008, 1'b0, 0, -1);
    applyStimulus(32'h3422F0F0, 1'b0, 0, -1);
    applyStimulus(32'h3C058000, 1'b0, 0, -1);
    applyStimulus(32'h00432023, 1'b0, 0, -1);
    applyStimulus(32'hAC040010, 1'b0, 0, -1);
    applyStimulus(32'h00000000, 1'b0, 0, -1);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(randInstr(), 1'($urandom), $urandom_range(0, 3), -1);
    end

    // sw interrupted by reset while its write request is up
    applyStimulus(32'hAC040010, 1'b0, 5, 5);
    checkOutput("swMemDmWE", 32'(dmWE), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRstDmWE",    32'(dmWE), 32'd0);
    checkOutput("midRstState",   32'(state), 32'd0);
    checkOutput("midRstRetired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    retiredModel = '0;

    applyStimulus(32'h00221821, 1'b0, 1, -1);
    applyStimulus(32'hFC000123, 1'b0, 0, -1);
    if (TRAP) doReset();
    applyStimulus(32'h8C040008, 1'b0, 2, -1);

    repeat (2) @(posedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared-ALU/shared-memory MIPS datapath.
- Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps.
- Drives per-step write enables and mux selects, and stalls in MEM on a memory-ready handshake.
- Counts retired instructions.
- Sits beside the datapath in the top level.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  current IR contents from the datapath.
- zero  in  1  ALU equality flag; valid in EXEC.
- memReady  in  1  data memory done; sampled in MEM.
- irWE  out  1  IR load.
- pcWE  out  1  PC load.
- regWE  out  1  register file write.
- dmWE  out  1  data memory write request.
- dmRE  out  1  data memory read request.
- aluOp  out  3  0 add, 1 sub, 2 or, 3 lui (imm<<16).
- aluSrc  out  1  0 rt, 1 immediate.
- usExt  out  1  1 zero-extend imm, 0 sign-extend.
- regDesCtrl  out  2  0 rt, 1 rd, 2 $31.
- regDataCtrl  out  2  0 ALU result register, 1 memory data register, 2 PC register.
- nextPCop  out  3  0 PC+4, 1 PC+(sext(imm)<<2), 2 {PC[31:28],idx,2'b0}, 3 rs.
- state  out  3  current FSM state.
- retired  out  RETIRE_W  completed instruction count.
- halted  out  1  illegal-instruction halt; only with the optional feature, else tied 0.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (async): state=FETCH, retired=0.
- While reset=1, all write enables (irWE, pcWE, regWE, dmWE, dmRE) are forced to 0.
- Outputs are combinational from state and instr; defaults are 0 when not listed.
- Decoded set:
  - R-type funct: addu 0x21, subu 0x23, jr 0x08.
  - Opcodes: ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03.
  - nop: instr==0.
- FETCH: irWE=1, pcWE=1, nextPCop=0 (PC becomes PC+4). Next state DECODE.
- DECODE: no enables. Next state EXEC.
- EXEC:
  - addu/subu: aluOp 0/1, aluSrc 0; next WB.
  - ori: aluOp 2, aluSrc 1, usExt 1; next WB.
  - lui: aluOp 3, aluSrc 1; next WB.
  - lw/sw: aluOp 0, aluSrc 1, usExt 0; next MEM.
  - beq: aluOp 1, pcWE=zero, nextPCop 1; next FETCH, retire.
  - j: pcWE 1, nextPCop 2; next FETCH, retire.
  - jal: pcWE 1, nextPCop 2, regWE 1, regDesCtrl 2, regDataCtrl 2 (regfile samples the old PC, already +4); next FETCH, retire.
  - jr: pcWE 1, nextPCop 3; next FETCH, retire.
  - nop / undecoded: no enables; next FETCH, retire.
- MEM:
  - lw holds dmRE=1; sw holds dmWE=1.
  - Requests stay asserted every cycle until memReady=1.
  - memReady=1 → lw goes to WB; sw goes to FETCH and retires.
  - memReady=0 → stay in MEM. No timeout.
  - memReady is ignored in any other state.
- WB: regWE=1.
  - R-type: regDesCtrl 1, regDataCtrl 0.
  - ori/lui: regDesCtrl 0, regDataCtrl 0.
  - lw: regDesCtrl 0, regDataCtrl 1.
  - Next FETCH, retire.
- Cycle counts (excluding stalls): R/ori/lui 4, lw 5, sw 4, beq/j/jal/jr/nop 3.
- Retire: retired increments by 1 on the clock edge leaving the final state of an instruction; wraps modulo 2^RETIRE_W.
- Mid-instruction reset: the FSM returns to FETCH immediately, with no partial write committed after reset asserts.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - An undecoded instruction in EXEC (other than instr==0) goes to HALT, with no retire.
  - HALT asserts halted=1 with all enables 0 and stays there until reset.
- When undefined:
  - Undecoded instructions execute as nop; HALT is unreachable and halted is constant 0.

Test Plan:
- Reset then addu $3,$1,$2 (0x00221821): states 0,1,2,4,0. WB has regWE=1, regDesCtrl=1, aluOp=0 in EXEC; retired=1.
- lw $4,8($0) (0x8C040008) with memReady low 3 cycles then high: dmRE=1 for 4 MEM cycles, then WB with regDataCtrl=1; total 8 cycles.
- beq $1,$2,+4 (0x10220004): zero=1 gives pcWE=1, nextPCop=1 in EXEC; zero=0 gives pcWE=0. Both take 3 cycles.
- jal 0x100 (0x0C000100): EXEC has pcWE=1, regWE=1, regDesCtrl=2, regDataCtrl=2; back in FETCH after 3 cycles.
- sw with reset asserted mid-MEM: dmWE drops immediately, state=0, retired=0.
- Opcode 0x3F: with MC_CTRL_ILLEGAL_TRAP_EN, state=5 and halted=1 after EXEC; without it, FETCH after 3 cycles and retired increments.
